// File: rtl/io_device_regfile.sv
// io_device_regfile: memory-mapped register device with cycle counter, status and queued
// read responses. The optional compare/irq block is enabled by IO_DEVICE_REGFILE_IRQ_EN.
module io_device_regfile #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BUS_WIDTH       = 512,
    parameter int NUM_REGS        = 8,
    parameter int WRITE_LATENCY   = 31,
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] n2m_request_address,
    input  logic [BUS_WIDTH-1:0]     n2m_request_data,
    input  logic                     n2m_request_read,
    input  logic                     n2m_request_write,
    input  logic                     mc_avail_o,
    output logic                     m2n_request_available,
    output logic                     m2n_response_valid,
    output logic [ADDRESS_WIDTH-1:0] m2n_response_address,
    output logic [BUS_WIDTH-1:0]     m2n_response_data
`ifdef IO_DEVICE_REGFILE_IRQ_EN
   ,output logic                     irq
`endif
);

    localparam int LANES = BUS_WIDTH / DATA_WIDTH;
    localparam int W     = $clog2(DATA_WIDTH / 8);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int RW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int PW    = $clog2(RESP_FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int BCW   = (WRITE_LATENCY > 0) ? $clog2(WRITE_LATENCY + 1) : 1;
    localparam int SW    = (DATA_WIDTH > 16) ? DATA_WIDTH : 16;

    localparam logic [6:0] CNT_IDX  = 7'(NUM_REGS);
    localparam logic [6:0] STAT_IDX = 7'(NUM_REGS + 1);

    logic [DATA_WIDTH-1:0]    regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]    counter;
    logic [BCW-1:0]           busy_cnt;
    logic [ADDRESS_WIDTH-1:0] q_addr [RESP_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    q_data [RESP_FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [CW-1:0]            fifo_count;

    logic [6:0]            idx;
    logic [LW-1:0]         lane;
    logic [RW-1:0]         ridx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [SW-1:0]         status;
    logic                  busy;
    logic                  is_reg;
    logic                  is_cnt;
    logic                  is_stat;
    logic                  accept_rd;
    logic                  accept_wr;
    logic                  push;
    logic                  pop;

    assign idx     = n2m_request_address[W +: 7];
    assign lane    = LW'(idx % 7'(LANES));
    assign ridx    = idx[RW-1:0];
    assign wr_data = n2m_request_data[DATA_WIDTH*int'(lane) +: DATA_WIDTH];
    assign is_reg  = idx < CNT_IDX;
    assign is_cnt  = idx == CNT_IDX;
    assign is_stat = idx == STAT_IDX;
    assign busy    = busy_cnt != '0;

    assign m2n_request_available = !busy && (fifo_count < CW'(RESP_FIFO_DEPTH));
    assign accept_rd = n2m_request_read && m2n_request_available;
    assign accept_wr = n2m_request_write && m2n_request_available;
    assign push      = accept_rd;
    assign pop       = (fifo_count != '0) && mc_avail_o;

    assign m2n_response_valid   = fifo_count != '0;
    assign m2n_response_address = q_addr[rd_ptr];
    assign m2n_response_data    = {LANES{q_data[rd_ptr]}};

`ifdef IO_DEVICE_REGFILE_IRQ_EN
    localparam logic [6:0] CMP_IDX = 7'(NUM_REGS + 2);
    localparam logic [6:0] IEN_IDX = 7'(NUM_REGS + 3);

    logic [DATA_WIDTH-1:0] compare;
    logic                  irq_en;
    logic                  is_cmp;
    logic                  is_ien;

    assign is_cmp = idx == CMP_IDX;
    assign is_ien = idx == IEN_IDX;

    // A match in the same cycle as a compare write keeps irq asserted
    always_ff @(posedge clk) begin
        if (!reset) begin
            compare <= '0;
            irq_en  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (accept_wr && is_cmp) compare <= wr_data;
            if (accept_wr && is_ien) irq_en <= wr_data[0];
            if (irq_en && counter == compare) irq <= 1'b1;
            else if (accept_wr && is_cmp) irq <= 1'b0;
        end
    end
`endif

    always_comb begin
        status = '0;
        status[CW-1:0] = fifo_count;
        status[8] = busy;
`ifdef IO_DEVICE_REGFILE_IRQ_EN
        status[9] = irq;
`endif
        rd_data = '0;
        unique case (1'b1)
            is_reg:  rd_data = regs[ridx];
            is_cnt:  rd_data = counter;
            is_stat: rd_data = status[DATA_WIDTH-1:0];
`ifdef IO_DEVICE_REGFILE_IRQ_EN
            is_cmp:  rd_data = compare;
            is_ien:  rd_data[0] = irq_en;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            counter  <= '0;
            busy_cnt <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            counter <= counter + DATA_WIDTH'(1);
            if (accept_wr) busy_cnt <= BCW'(WRITE_LATENCY);
            else if (busy) busy_cnt <= busy_cnt - BCW'(1);
            if (accept_wr && is_reg) regs[ridx] <= wr_data;
        end
    end

    // Queue storage is cleared so the response outputs read 0 after reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
        end else begin
            if (push) begin
                q_addr[wr_ptr] <= n2m_request_address;
                q_data[wr_ptr] <= rd_data;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_device_regfile.sv
// Self-checking bench for io_device_regfile: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_io_device_regfile;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BUSW  = 512;
    localparam int NR    = 8;
    localparam int WL    = 31;
    localparam int DEPTH = 4;
    localparam int LANES = BUSW / DW;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   n2m_request_address;
    logic [BUSW-1:0] n2m_request_data;
    logic            n2m_request_read;
    logic            n2m_request_write;
    logic            mc_avail_o;
    logic            m2n_request_available;
    logic            m2n_response_valid;
    logic [AW-1:0]   m2n_response_address;
    logic [BUSW-1:0] m2n_response_data;
`ifdef IO_DEVICE_REGFILE_IRQ_EN
    logic            irq;
`endif

    always #5 clk = ~clk;

    io_device_regfile #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BUS_WIDTH(BUSW),
        .NUM_REGS(NR), .WRITE_LATENCY(WL), .RESP_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .n2m_request_address(n2m_request_address),
        .n2m_request_data(n2m_request_data),
        .n2m_request_read(n2m_request_read),
        .n2m_request_write(n2m_request_write),
        .mc_avail_o(mc_avail_o),
        .m2n_request_available(m2n_request_available),
        .m2n_response_valid(m2n_response_valid),
        .m2n_response_address(m2n_response_address),
        .m2n_response_data(m2n_response_data)
`ifdef IO_DEVICE_REGFILE_IRQ_EN
       ,.irq(irq)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [BUSW-1:0] act,
                         input logic [BUSW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: register file, cycle count, busy deadline, response queue
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } resp_t;

    resp_t         mq[$];
    logic [DW-1:0] mregs[NR];
    logic [DW-1:0] mcnt;
    logic [DW-1:0] mcmp;
    bit            men;
    bit            mirq;
    bit            m_nirq;
    bit            started = 0;
    bit            clean;
    longint        edge_n = 0;
    longint        free_at = 0;
    logic [DW-1:0] m_rv;
    int            m_i;
    bit            m_av;

    function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
        int i;
        i = int'(a[2 +: 7]);
        if (i < NR) return mregs[i];
        if (i == NR) return mcnt;
        if (i == NR + 1) return DW'({mirq, (edge_n < free_at), 8'(mq.size())});
`ifdef IO_DEVICE_REGFILE_IRQ_EN
        if (i == NR + 2) return mcmp;
        if (i == NR + 3) return DW'(men);
`endif
        return '0;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NR; r++) mregs[r] = '0;
            mq.delete();
            mcnt = '0; mcmp = '0; men = 0; mirq = 0;
            free_at = 0; started = 1; clean = 1;
        end else if (started) begin
            m_av = !(edge_n < free_at) && (mq.size() < DEPTH);
            m_rv = mread(n2m_request_address);
            m_i  = int'(n2m_request_address[2 +: 7]);
            m_nirq = mirq;
`ifdef IO_DEVICE_REGFILE_IRQ_EN
            if (men && mcnt == mcmp) m_nirq = 1;
            else if (m_av && n2m_request_write && m_i == NR + 2) m_nirq = 0;
`endif
            if (mq.size() > 0 && mc_avail_o) void'(mq.pop_front());
            if (m_av && n2m_request_read) begin
                mq.push_back('{a: n2m_request_address, d: m_rv});
                clean = 0;
            end
            if (m_av && n2m_request_write) begin
                if (m_i < NR) mregs[m_i] = n2m_request_data[(m_i % LANES)*DW +: DW];
`ifdef IO_DEVICE_REGFILE_IRQ_EN
                if (m_i == NR + 2) mcmp = n2m_request_data[(m_i % LANES)*DW +: DW];
                if (m_i == NR + 3) men = n2m_request_data[(m_i % LANES)*DW];
`endif
                free_at = edge_n + 1 + WL;
            end
            mirq = m_nirq;
            mcnt = mcnt + 1;
        end
        edge_n++;
    end

    always @(negedge clk) begin
        if (started) begin
            check("avail", m2n_request_available,
                  !(edge_n < free_at) && (mq.size() < DEPTH));
            check("valid", m2n_response_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                check("resp_addr", m2n_response_address, mq[0].a);
                check("resp_data", m2n_response_data, {LANES{mq[0].d}});
            end else if (clean) begin
                check("idle_addr", m2n_response_address, '0);
                check("idle_data", m2n_response_data, '0);
            end
`ifdef IO_DEVICE_REGFILE_IRQ_EN
            check("irq", irq, mirq);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_avail();
        int n = 0;
        while (!m2n_request_available && n < 200) begin
            step();
            n++;
        end
        check("avail_wait", m2n_request_available, 1);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        wait_avail();
        n2m_request_read = 1; n2m_request_address = a;
        step();
        n2m_request_read = 0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [BUSW-1:0] d);
        wait_avail();
        n2m_request_write = 1; n2m_request_address = a; n2m_request_data = d;
        step();
        n2m_request_write = 0;
    endtask

    logic [BUSW-1:0] bus;
    logic [BUSW-1:0] lanes_bus;
    logic [DW-1:0]   ca;
    logic [DW-1:0]   cb;
    int              n;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 0; n2m_request_read = 0; n2m_request_write = 0;
        n2m_request_address = '0; n2m_request_data = '0; mc_avail_o = 1;
        for (int k = 0; k < LANES; k++) lanes_bus[k*DW +: DW] = DW'(32'h1000 + k);
        repeat (3) step();
        check("rst_avail", m2n_request_available, 1);
        check("rst_valid", m2n_response_valid, 0);
        check("rst_addr", m2n_response_address, 0);
        check("rst_data", m2n_response_data, 0);
        reset = 1;
        step();

        for (int i = 0; i < NR; i++) begin
            do_read(AW'(i * 4));
            check("rd_valid", m2n_response_valid, 1);
            check("rd_addr", m2n_response_address, i * 4);
            check("rd_data", m2n_response_data, 0);
        end
        step();

        bus = '0;
        bus[2*DW +: DW] = 32'hDEADBEEF;
        do_write(32'h8, bus);
        n = 0;
        while (!m2n_request_available && n < 100) begin
            n++;
            step();
        end
        check("busy_cycles", n, 31);
        do_read(32'h8);
        check("rd_idx2", m2n_response_data, {16{32'hDEADBEEF}});

        do_write(32'h14, lanes_bus);
        do_read(32'h14);
        check("lane_idx5", m2n_response_data, {16{32'h00001005}});
        do_write(32'h44, lanes_bus);
        do_read(32'h44);
        check("oor_read", m2n_response_data, 0);
        do_read(32'h8);
        check("idx2_kept", m2n_response_data, {16{32'hDEADBEEF}});

        do_read(32'h20);
        ca = m2n_response_data[DW-1:0];
        repeat (9) step();
        n2m_request_read = 1; n2m_request_address = 32'h20;
        step();
        n2m_request_read = 0;
        cb = m2n_response_data[DW-1:0];
        check("cnt_delta", cb - ca, 10);

        step();
        mc_avail_o = 0;
        for (int i = 0; i < 5; i++) begin
            n2m_request_read = 1; n2m_request_address = AW'(i * 4);
            step();
            if (i == 3) check("full_avail", m2n_request_available, 0);
        end
        n2m_request_read = 0;
        for (int i = 0; i < 4; i++) begin
            check("order_addr", m2n_response_address, i * 4);
            mc_avail_o = 1;
            step();
        end
        check("drained", m2n_response_valid, 0);

        mc_avail_o = 0;
        do_read(32'h0);
        do_read(32'h24);
        mc_avail_o = 1;
        step();
        check("stat_addr", m2n_response_address, 32'h24);
        check("stat_data", m2n_response_data, {16{32'h1}});
        step();

        mc_avail_o = 0;
        do_read(32'h0);
        do_read(32'h4);
        do_write(32'hC, lanes_bus);
        repeat (11) step();
        reset = 0;
        n2m_request_write = 1; n2m_request_address = 32'h10; n2m_request_data = lanes_bus;
        step();
        check("mid_rst_valid", m2n_response_valid, 0);
        check("mid_rst_avail", m2n_request_available, 1);
        reset = 1; n2m_request_write = 0; mc_avail_o = 1;
        do_read(32'hC);
        check("rst_idx3", m2n_response_data, 0);
        do_read(32'h10);
        check("rst_idx4", m2n_response_data, 0);
        do_read(32'h8);
        check("rst_idx2", m2n_response_data, 0);

        wait_avail();
        n2m_request_read = 1; n2m_request_write = 1;
        n2m_request_address = 32'h4; n2m_request_data = lanes_bus;
        step();
        n2m_request_read = 0; n2m_request_write = 0;
        check("rw_pre", m2n_response_data, 0);
        do_read(32'h4);
        check("rw_post", m2n_response_data, {16{32'h00001001}});

`ifdef IO_DEVICE_REGFILE_IRQ_EN
        step();
        do_read(32'h20);
        ca = m2n_response_data[DW-1:0];
        bus = '0;
        bus[10*DW +: DW] = ca + 50;
        do_write(32'h28, bus);
        bus = '0;
        bus[11*DW +: DW] = 1;
        do_write(32'h2C, bus);
        check("irq_idle", irq, 0);
        n = 0;
        while (!irq && n < 100) begin
            n++;
            step();
        end
        check("irq_rise", irq, 1);
        do_read(32'h24);
        check("irq_status", m2n_response_data, {16{32'h200}});
        bus = '0;
        do_write(32'h28, bus);
        check("irq_clear", irq, 0);
`endif

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
